// File: rtl/ldtu_deser_align.sv
// ldtu_deser_align: serial-to-word deserializer locking to an idle pattern; LDTU_DESER_ERRCNT_EN enables the lock-loss counter
module ldtu_deser_align #(
  parameter logic [31:0] IDLE_PATTERN = 32'hEAAAAAAA,
  parameter int N_CONFIRM = 4,
  parameter int SLIP_MAX = 4
) (
  input  logic        clock,
  input  logic        rst_b,
  input  logic        ser_in,
  input  logic        enable,
  input  logic        realign,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        idle_seen,
  output logic        locked,
  output logic [1:0]  align_state,
  output logic [7:0]  align_err_cnt
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [7:0] NC = 8'(N_CONFIRM);
  localparam logic [7:0] SM = 8'(SLIP_MAX);
  state_t state;
  logic [31:0] sr;
  logic [4:0] bit_cnt;
  logic [7:0] conf_cnt, slip_cnt;
  logic is_idle;
  assign is_idle = sr == IDLE_PATTERN;
  assign align_state = state;
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      sr <= '0;
      bit_cnt <= '0;
      conf_cnt <= '0;
      slip_cnt <= '0;
      state <= HUNT;
      locked <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
      idle_seen <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      idle_seen <= 1'b0;
      if (enable) sr <= {sr[30:0], ser_in};
      if (realign) begin
        state <= HUNT;
        locked <= 1'b0;
        bit_cnt <= '0;
        conf_cnt <= '0;
        slip_cnt <= '0;
      end else if (enable) begin
        case (state)
          HUNT: if (is_idle) begin
            bit_cnt <= 5'd1;
            conf_cnt <= 8'd1;
            state <= VERIFY;
          end
          VERIFY: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) begin
              if (is_idle) begin
                conf_cnt <= conf_cnt + 8'd1;
                if (conf_cnt + 8'd1 == NC) begin
                  state <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                state <= HUNT;
                bit_cnt <= '0;
                conf_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) begin
              word_out <= sr;
              word_valid <= !is_idle;
              idle_seen <= is_idle;
              if (is_idle) slip_cnt <= '0;
            end else if (is_idle) begin
              // an idle word off the word grid means the bit clock slipped
              if (slip_cnt + 8'd1 == SM) begin
                state <= HUNT;
                locked <= 1'b0;
                bit_cnt <= '0;
                conf_cnt <= '0;
                slip_cnt <= '0;
              end else slip_cnt <= slip_cnt + 8'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
`ifdef LDTU_DESER_ERRCNT_EN
  logic [7:0] err_cnt;
  logic slip_loss;
  assign slip_loss = enable && !realign && state == LOCKED && bit_cnt != 5'd0 && is_idle && slip_cnt + 8'd1 == SM;
  always_ff @(posedge clock) begin
    if (!rst_b) err_cnt <= '0;
    else if (slip_loss && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
  assign align_err_cnt = err_cnt;
`else
  assign align_err_cnt = '0;
`endif
endmodule
